// File: rtl/aes_inv_cipher_if.sv
// Start/result bus of the iterative AES-128 inverse cipher.
// The same signal set as the encryptor, so the two chain directly in loopback.
interface aes_inv_cipher_if;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;

    modport master (
        output AES_en, AES_data_in, AES_key_in,
        input  AES_data_out, AES_data_out_valid, AES_busy
    );

    modport slave (
        input  AES_en, AES_data_in, AES_key_in,
        output AES_data_out, AES_data_out_valid, AES_busy
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Forward expansion reaches round key 10, then the schedule is unwound during decryption.
module aes_inv_cipher #(
    parameter bit KEY_CACHE = 1'b1
) (
    input logic             AES_clk,
    input logic             AES_rst_n,
    aes_inv_cipher_if.slave bus
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry x sits at the x-th byte from the MSB end of each table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a constant whose bits select a, 2a, 4a, 8a.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_e;

    state_e       state_q;
    logic [3:0]   rc_q;
    logic [127:0] key_q, blk_q, data_out_q, cache_key_q, cache_rk10_q;
    logic         valid_q, busy_q, cache_valid_q;

    logic [127:0] key_d, blk_d, ark, imc;
    logic [31:0]  w0, w1, w2, w3, sub_in, rot, g, n0;
    logic [7:0]   sb_b [16];
    logic         cache_hit;

    // rc_q counts 0..9 in KEYEXP and 9..0 in ROUND; both directions use Rcon[rc_q+1].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        key_d  = '0;
        n0     = '0;
        {w0, w1, w2, w3} = key_q;
        sub_in = (state_q == ROUND) ? (w3 ^ w2) : w3;
        rot    = {sub_in[23:0], sub_in[31:24]};
        g      = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon(rc_q + 4'd1), 24'h0};
        if (state_q == ROUND) begin
            key_d = {w0 ^ g, w1 ^ w0, w2 ^ w1, w3 ^ w2};
        end else begin
            n0    = w0 ^ g;
            key_d = {n0, n0 ^ w1, n0 ^ w1 ^ w2, n0 ^ w1 ^ w2 ^ w3};
        end
    end

    // InvShiftRows folded into the S-box input selection: row r shifts right by r.
    always_comb begin
        ark = '0;
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb_b[4*c+r] = inv_sbox(blk_q[8*(15 - (4*((c - r) & 3) + r)) +: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ark[8*(15-i) +: 8] = sb_b[i] ^ key_d[8*(15-i) +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            imc[32*(3-c) +: 32] = inv_mix_col(ark[32*(3-c) +: 32]);
        end
        blk_d = (rc_q == 4'd0) ? ark : imc;
    end

    assign cache_hit = KEY_CACHE && cache_valid_q && (bus.AES_key_in == cache_key_q);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            state_q       <= IDLE;
            rc_q          <= '0;
            key_q         <= '0;
            blk_q         <= '0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_rk10_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.AES_en) begin
                        busy_q <= 1'b1;
                        if (cache_hit) begin
                            key_q   <= cache_rk10_q;
                            blk_q   <= bus.AES_data_in ^ cache_rk10_q;
                            rc_q    <= 4'd9;
                            state_q <= ROUND;
                        end else begin
                            key_q         <= bus.AES_key_in;
                            blk_q         <= bus.AES_data_in;
                            rc_q          <= 4'd0;
                            cache_valid_q <= 1'b0;
                            cache_key_q   <= bus.AES_key_in;
                            state_q       <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= key_d;
                    rc_q  <= rc_q + 4'd1;
                    if (rc_q == 4'd9) begin
                        blk_q         <= blk_q ^ key_d;
                        rc_q          <= 4'd9;
                        cache_rk10_q  <= key_d;
                        cache_valid_q <= 1'b1;
                        state_q       <= ROUND;
                    end
                end
                ROUND: begin
                    key_q <= key_d;
                    blk_q <= blk_d;
                    rc_q  <= rc_q - 4'd1;
                    if (rc_q == 4'd0) begin
                        data_out_q <= blk_d;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.AES_data_out       = data_out_q;
    assign bus.AES_data_out_valid = valid_q;
    assign bus.AES_busy           = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: a forward AES model produces ciphertext,
// a timing model predicts start edges, and the monitor checks each result.
module tb_aes_inv_cipher;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    aes_inv_cipher_if bus ();
    aes_inv_cipher_if bus_nc ();

    aes_inv_cipher #(.KEY_CACHE(1'b1)) u_dut    (.AES_clk(clk), .AES_rst_n(rst_n), .bus(bus));
    aes_inv_cipher #(.KEY_CACHE(1'b0)) u_dut_nc (.AES_clk(clk), .AES_rst_n(rst_n), .bus(bus_nc));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           start;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           m_rem = 0;
    logic         m_cvalid = 1'b0;
    logic [127:0] m_ckey = '0;
    logic [7:0]   sb_tab [256];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // ---------------- reference forward cipher ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] sq, inv, b;
            sq  = 8'(x);
            inv = 8'h01;
            for (int k = 1; k < 8; k++) begin
                sq  = gmul(sq, sq);
                inv = gmul(inv, sq);
            end
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_tab[x] = b;
        end
    endtask

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb_tab[w3[23:16]], sb_tab[w3[15:8]], sb_tab[w3[7:0]], sb_tab[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [127:0] k, res;
        k  = key;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[8*(15-i) +: 8] ^ key[8*(15-i) +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c + row) % 4) + row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k  = kexp(k, rc);
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] ^= k[8*(15-i) +: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus with timing model ----------------
    task automatic step(input logic en, input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] pt);
        logic hit;
        bus.AES_en      = en;
        bus.AES_data_in = ct;
        bus.AES_key_in  = key;
        if (m_rem > 0) begin
            m_rem--;
        end else if (en) begin
            hit = m_cvalid && (key == m_ckey);
            sb_q.push_back('{pt: pt, start: cyc + 1, lat: hit ? 10 : 20});
            m_rem = hit ? 10 : 20;
            if (!hit) begin
                m_cvalid = 1'b1;
                m_ckey   = key;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("busy", {127'b0, bus.AES_busy}, {127'b0, m_rem != 0});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_rem > 0 && n < 40) begin
            step(1'b0, '0, '0, '0);
            n++;
        end
        step(1'b0, '0, '0, '0);
        check("queue_empty", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.AES_en     = 1'b0;
        bus_nc.AES_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_data_out", bus.AES_data_out, '0);
        check("rst_valid", {127'b0, bus.AES_data_out_valid}, '0);
        check("rst_busy", {127'b0, bus.AES_busy}, '0);
        rst_n    = 1'b1;
        m_rem    = 0;
        m_cvalid = 1'b0;
        sb_q.delete();
    endtask

    task automatic run_nc(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
        int start, n;
        bus_nc.AES_en      = 1'b1;
        bus_nc.AES_data_in = ct;
        bus_nc.AES_key_in  = key;
        start = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        bus_nc.AES_en = 1'b0;
        n = 0;
        while (!bus_nc.AES_data_out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!bus_nc.AES_data_out_valid) begin
            check("nc_timeout", 128'd0, 128'd1);
        end else begin
            check("nc_latency", 128'(cyc - start), 128'd20);
            check("nc_plaintext", bus_nc.AES_data_out, pt);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.AES_data_out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("latency", 128'(cyc - e.start), 128'(e.lat));
                check("plaintext", bus.AES_data_out, e.pt);
            end
        end
    end

    initial begin
        logic [127:0] k, p;
        build_sbox();
        rst_n              = 1'b0;
        bus.AES_en         = 1'b0;
        bus.AES_data_in    = '0;
        bus.AES_key_in     = '0;
        bus_nc.AES_en      = 1'b0;
        bus_nc.AES_data_in = '0;
        bus_nc.AES_key_in  = '0;
        @(negedge clk);
        do_reset();

        // FIPS-197 C.1
        step(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff);
        drain();

        // Appendix B vector twice: second job hits the key cache.
        for (int j = 0; j < 2; j++) begin
            step(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3243f6a8885a308d313198a2e0370734);
            drain();
        end

        // No-cache instance: both jobs take the full 20 cycles.
        for (int j = 0; j < 2; j++)
            run_nc(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3243f6a8885a308d313198a2e0370734);

        // Back-to-back with data changing every cycle under the all-zero key.
        step(1'b1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, '0);
        for (int i = 1; i < 60; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, aes_enc(p, '0), '0, p);
        end
        drain();

        // Reset during the 8th ROUND cycle, then the same key must expand again.
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, aes_enc(p, k), k, p);
        for (int i = 0; i < 17; i++) step(1'b0, '0, '0, '0);
        do_reset();
        step(1'b1, aes_enc(p, k), k, p);
        drain();

        // Loopback: random pairs, keys reused in runs of four to mix hits and misses.
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, aes_enc(p, k), k, p);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher.md
Name: aes_inv_cipher

Overview:
- Iterative AES-128 inverse cipher: one round per clock; returns plaintext for a ciphertext/key pair.
- Receive-side counterpart of the AES_top encryptor; same port style and handshake, so the two can be chained in loopback benches.
- Forward key expansion runs to round key 10, then the inverse key schedule runs on the fly during decryption.
- An optional cache keeps round key 10 so a repeated key skips expansion.

Parameters:
- KEY_CACHE, 1: 1 keeps the last expanded round key 10 and skips KEYEXP when the key matches; 0 always expands.

Ports:
- AES_clk  input  1  clock; all state changes on the rising edge.
- AES_rst_n  input  1  reset, synchronous, active-low.
- AES_en  input  1  start request, level-sensitive; sampled only in IDLE.
- AES_data_in  input  128  ciphertext; bit 127 is byte 0 of the state.
- AES_key_in  input  128  cipher key, same byte order.
- AES_data_out  output  128  plaintext; holds until the next completion.
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates.
- AES_busy  output  1  high in KEYEXP and ROUND.

Behaviour:
- Reset (AES_rst_n=0 at an edge), taking priority over everything, including mid-operation:
  - state to IDLE; AES_data_out=0; AES_data_out_valid=0; AES_busy=0; cache flag cleared; in-flight job discarded with no valid pulse.
- FSM states: IDLE, KEYEXP, ROUND.
- IDLE with AES_en=1 at edge E:
  - Latch ct and key, round counter rc=0.
  - If KEY_CACHE=1, the cache is valid and AES_key_in equals the cached key: load the key register with cached rk10, state <= ct XOR rk10, go to ROUND.
  - Otherwise: key register <= key, go to KEYEXP.
- KEYEXP, 10 cycles:
  - Each edge applies one forward expansion step with Rcon 01,02,04,08,10,20,40,80,1b,36.
  - On the 10th edge (E+10): key register = rk10; state <= ct XOR rk10; rk10 and key stored to the cache with the cache flag set; go to ROUND.
- ROUND, 10 cycles, r = 9 down to 0:
  - Each edge: key <= inverse-expansion(key), giving rk_r; state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_r).
  - The r=0 round omits InvMixColumns.
  - On the r=0 edge: AES_data_out <= result; AES_data_out_valid=1 for exactly that one following cycle; go to IDLE.
- Latency from the start edge E to the result edge: 20 cycles without a cache hit, 10 with a hit.
  - Valid is high during the cycle after edge E+20 (or E+10).
- Back-to-back: AES_en held high restarts on the first IDLE edge after the valid edge.
  - Throughput is one block per 21 cycles (11 with a cache hit).
- AES_data_in and AES_key_in changes while busy are ignored; inputs are latched only at start.
- AES_en deasserting while busy does not abort the job.
- Inverse key step, on words w0..w3 of rk_i:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon_i.
  - Rcon is indexed by a counter, never a table walk past index 10.
- S-box and inverse S-box are combinational ROM functions.
  - 16 inverse S-boxes on the data path; 4 forward S-boxes on the key path.
  - No RAM.

Test Plan:
- FIPS-197 C.1 vector, reset then AES_en=1 for one cycle:
  - Inputs: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: AES_data_out=00112233445566778899aabbccddeeff with valid high exactly once, 20 cycles after the start edge; AES_busy high for 20 cycles.
- Same key repeated, ct 3925841d02dc09fbdc118597196a0b32 under key 2b7e151628aed2a6abf7158809cf4f3c, then a second job reusing that key (KEY_CACHE=1):
  - Required: first result 3243f6a8885a308d313198a2e0370734 at 20 cycles; second result correct at 10 cycles.
  - With KEY_CACHE=0 both jobs take 20 cycles.
- Key all-zero, ct 66e94bd4ef8a2c3b884cfa59ca342b2e, with AES_en held high for 60 cycles and AES_data_in changed every cycle while busy:
  - Required: first output 00000000000000000000000000000000.
  - Restarts happen one idle edge after each valid pulse.
  - Each job's output matches the data sampled at its own start edge.
- Reset asserted at cycle 8 of ROUND:
  - Required: next cycle AES_data_out=0, AES_data_out_valid=0, AES_busy=0.
  - No valid pulse for the aborted job.
  - A following start with the same key takes 20 cycles, because the cache was cleared.
- Loopback: AES_top encrypts a random plaintext with a random key; its output feeds this block under the same key.
  - Required: recovered plaintext equals the original across 200 random pairs.
